// File: rtl/fpu_resp_serializer.sv
// Buffers FPU result elements {eom,flags,result} and serializes each one as a byte stream.
// Optional macro FPU_RESP_PARITY_EN appends an XOR parity byte to every element.
module fpu_resp_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_result,
  input  logic [FLAG_WIDTH-1:0]   in_flags,
  input  logic                    in_eom,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_last,
  output logic                    tx_eom,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    eom_sent
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + FLAG_WIDTH + DATA_WIDTH;
  localparam int IW = 3;
`ifdef FPU_RESP_PARITY_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            eom_sent_q, eom_sent_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic [EW-1:0]         head;
  logic [DATA_WIDTH-1:0] head_result;
  logic [FLAG_WIDTH-1:0] head_flags;
  logic                  head_eom;
  logic                  push, hs, last, pop;

  function automatic logic [7:0] elem_byte(input logic [31:0] r, input logic [7:0] f,
                                           input logic [IW-1:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = r[7:0];
      3'd1:    b = r[15:8];
      3'd2:    b = r[23:16];
      3'd3:    b = r[31:24];
      3'd4:    b = f;
`ifdef FPU_RESP_PARITY_EN
      3'd5:    b = r[7:0] ^ r[15:8] ^ r[23:16] ^ r[31:24] ^ f;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign head        = mem_q[rd_ptr_q];
  assign head_result = head[DATA_WIDTH-1:0];
  assign head_flags  = head[DATA_WIDTH +: FLAG_WIDTH];
  assign head_eom    = head[EW-1];

  assign in_ready = (count_q != CW'(DEPTH)) && !eom_sent_q && !reset;
  assign pending  = count_q;
  assign eom_sent = eom_sent_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    eom_sent_d = eom_sent_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    tx_eom     = 1'b0;

    push = in_valid && in_ready;
    hs   = (state_q == SEND) && tx_ready;
    last = (idx_q == IW'(NB - 1));
    pop  = hs && last;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = elem_byte(head_result, head_flags, idx_q);
        tx_last  = last;
        tx_eom   = last && head_eom;
        if (hs) begin
          if (last) begin
            idx_d = '0;
            if (head_eom) eom_sent_d = 1'b1;
            // A push in the same cycle keeps the stream gap-free.
            if (count_d == '0) state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      eom_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      eom_sent_q <= eom_sent_d;
    end
  end

  // Element storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_eom, in_flags, in_result};
  end

endmodule

// File: tb/tb_fpu_resp_serializer.sv
// Directed bench for fpu_resp_serializer; byte count follows FPU_RESP_PARITY_EN.
module tb_fpu_resp_serializer;

`ifdef FPU_RESP_PARITY_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [7:0]  in_flags;
  logic        in_eom;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_eom;
  logic [2:0]  pending;
  logic        eom_sent;

  int checks = 0;
  int errors = 0;

  fpu_resp_serializer #(.DATA_WIDTH(32), .FLAG_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_eom(in_eom),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_eom(tx_eom), .pending(pending), .eom_sent(eom_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] r, input logic [7:0] f, input int i);
    case (i)
      0: return r[7:0];
      1: return r[15:8];
      2: return r[23:16];
      3: return r[31:24];
      4: return f;
      5: return r[7:0] ^ r[15:8] ^ r[23:16] ^ r[31:24] ^ f;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic [7:0] f, input logic e);
    in_result = r;
    in_flags  = f;
    in_eom    = e;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Expects the DUT to be presenting byte 0 of this element; stall=1 drives tx_ready 1,0,0,1,...
  task automatic recv_elem(input logic [31:0] r, input logic [7:0] f, input logic e, input bit stall);
    int i = 0;
    int cyc = 0;
    while (i < NB && cyc < 200) begin
      tx_ready = stall ? (cyc % 3 == 0) : 1'b1;
      chk("tx_valid", tx_valid, 1'b1);
      chk("tx_data", tx_data, exp_byte(r, f, i));
      chk("tx_last", tx_last, (i == NB - 1));
      chk("tx_eom", tx_eom, e && (i == NB - 1));
      tick();
      if (tx_ready) i++;
      cyc++;
    end
    chk("recv_bytes", i, NB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_eom = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_pending", pending, 3'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_eom_sent", eom_sent, 1'b0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);

    // Basic element, continuous ready, first byte one cycle after acceptance
    tx_ready = 1'b1;
    push(32'h3F80_0000, 8'h00, 1'b0);
    chk("lat_tx_valid", tx_valid, 1'b0);
    chk("lat_pending", pending, 3'd1);
    tick();
    chk("t1_byte2", tx_data, (NB > 0) ? 8'h00 : 8'hFF);
    recv_elem(32'h3F80_0000, 8'h00, 1'b0, 1'b0);
    chk("t1_done_valid", tx_valid, 1'b0);
    chk("t1_done_pending", pending, 3'd0);

    // Stalling consumer
    push(32'h4049_0FDB, 8'h04, 1'b0);
    tick();
    recv_elem(32'h4049_0FDB, 8'h04, 1'b0, 1'b1);
    chk("t2_done_valid", tx_valid, 1'b0);

    // Fill to DEPTH with consumer blocked; fifth offer refused
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_result = 32'h1111_1111 * (k + 1);
      in_flags  = 8'h10 + 8'(k);
      in_eom    = 1'b0;
      in_valid  = 1'b1;
      chk("t3_in_ready", in_ready, (k < 4));
      tick();
    end
    in_valid = 1'b0;
    chk("t3_pending_full", pending, 3'd4);
    for (int k = 0; k < 4; k++) recv_elem(32'h1111_1111 * (k + 1), 8'h10 + 8'(k), 1'b0, 1'b0);
    chk("t3_drained_valid", tx_valid, 1'b0);
    chk("t3_drained_pending", pending, 3'd0);

    // Reset in the middle of an element
    push(32'hC000_0000, 8'h08, 1'b0);
    tick();
    tx_ready = 1'b1;
    chk("t5_b0", tx_data, 8'h00);
    tick();
    chk("t5_b1", tx_data, 8'h00);
    tick();
    chk("t5_b2", tx_data, 8'h00);
    tx_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", tx_valid, 1'b0);
    chk("t5_rst_pending", pending, 3'd0);
    chk("t5_rst_in_ready", in_ready, 1'b0);
    chk("t5_rst_last", tx_last, 1'b0);
    reset = 1'b0;
    tick();
    chk("t5_post_in_ready", in_ready, 1'b1);
    push(32'hA5B6_C7D8, 8'h40, 1'b0);
    tick();
    recv_elem(32'hA5B6_C7D8, 8'h40, 1'b0, 1'b0);

`ifdef FPU_RESP_PARITY_EN
    push(32'h3F80_0000, 8'h01, 1'b0);
    tick();
    recv_elem(32'h3F80_0000, 8'h01, 1'b0, 1'b0);
    chk("t6_done_valid", tx_valid, 1'b0);
`endif

    // End of message, plus one element queued behind it
    tx_ready = 1'b0;
    push(32'h7FC0_0000, 8'h20, 1'b1);
    push(32'h1234_5678, 8'hFF, 1'b0);
    chk("t4_pending", pending, 3'd2);
    chk("t4_eom_pre", eom_sent, 1'b0);
    recv_elem(32'h7FC0_0000, 8'h20, 1'b1, 1'b0);
    chk("t4_eom_sent", eom_sent, 1'b1);
    chk("t4_in_ready", in_ready, 1'b0);
    chk("t4_pending_tail", pending, 3'd1);
    recv_elem(32'h1234_5678, 8'hFF, 1'b0, 1'b0);
    chk("t4_tail_pending", pending, 3'd0);
    push(32'hDEAD_BEEF, 8'h00, 1'b0);
    chk("t4_refused_pending", pending, 3'd0);
    tick();
    chk("t4_refused_valid", tx_valid, 1'b0);
    chk("t4_sticky", eom_sent, 1'b1);
    chk("t4_in_ready_late", in_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
